bus_slave: RTL

Serial-bus slave endpoint: deserialises the 16-bit address and 8-bit write data driven by a bus master on the shared serial line and decodes the address against its own window. It acknowledges hits, commits writes into a local byte register file, and serialises read data back to the master. It sits directly downstream of the bus master, on the far side of the serial bus.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/counter.sv | 30 +++
 rtl/bus_slave.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions used by both the bus master and the slave endpoint.
//   slv_state_t : slave transaction phases
//   ADDR_BITS   : serial address width (LSB first on the wire)
//   DATA_BITS   : serial data width
//   ACK_CYCLES  : length of every acknowledge window
package bus_pkg;

    localparam int unsigned ADDR_BITS  = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned ACK_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        ACKA  = 3'd2,
        WDATA = 3'd3,
        ACKW  = 3'd4,
        RDATA = 3'd5
    } slv_state_t;

endpackage

// File: rtl/counter.sv
// Shared up-counter with synchronous clear.
//   CLK, RSTN : clock, asynchronous active-high reset
//   rst       : synchronous clear, wins over incr
//   incr      : count enable
//   cnt_o     : current count
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             rst,
    input  logic             incr,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            cnt_q <= '0;
        end else if (rst) begin
            cnt_q <= '0;
        end else if (incr) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_slave.sv
// Serial-bus slave endpoint: deserialises address/write data, decodes its
// address window, acks hits, commits writes to a local byte register file and
// serialises read data back MSB first.
//   CLK, RSTN        : clock, asynchronous active-high reset
//   B_UTIL           : master drives / consumes a valid bit this cycle
//   B_RW             : 1 = write, 0 = read (latched on address bit 0)
//   B_BUS_IN         : serial data from master
//   B_BUS_OUT        : serial read data to master
//   B_ACK            : acknowledge during ack windows
//   S_WEN            : one-cycle pulse on write commit
//   S_WADDR, S_WDATA : offset and data of the committed write
module bus_slave
    import bus_pkg::*;
#(
    parameter logic [ADDR_BITS-1:0] BASE_ADDR  = 16'h1000,
    parameter int unsigned          DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  B_UTIL,
    input  logic                  B_RW,
    input  logic                  B_BUS_IN,
    output logic                  B_BUS_OUT,
    output logic                  B_ACK,
    output logic                  S_WEN,
    output logic [DEPTH_LOG2-1:0] S_WADDR,
    output logic [DATA_BITS-1:0]  S_WDATA
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    // Bit 0 is taken in IDLE, so the counter sees bits 1..15 as 0..14.
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_BITS - 2);
    localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ACK_LAST  = CNT_W'(ACK_CYCLES - 1);

    slv_state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt;
    logic                  cnt_clr, cnt_incr;
    logic                  rw_q;
    logic [ADDR_BITS-2:0]  addr_q;
    logic [DATA_BITS-2:0]  wd_q;
    logic                  hit_q;
    logic [DEPTH_LOG2-1:0] off_q;
    logic [DATA_BITS-1:0]  rd_q, rd_d;
    logic [DATA_BITS-1:0]  mem_q [DEPTH];

    logic [ADDR_BITS-1:0]  addr_full, addr_diff;
    logic [DATA_BITS-1:0]  wbyte;
    logic [DEPTH_LOG2-1:0] off_calc;
    logic                  hit_calc, hit_now;
    logic                  last_addr, commit;
    logic                  ack_d, bus_out_d, wen_d;
    logic [DEPTH_LOG2-1:0] waddr_d;
    logic [DATA_BITS-1:0]  wdata_d;

    // Full words are completed by the bit arriving this cycle.
    assign addr_full = {B_BUS_IN, addr_q};
    assign wbyte     = {B_BUS_IN, wd_q};
    assign addr_diff = addr_full - BASE_ADDR;
    assign hit_calc  = 32'(addr_diff) < DEPTH;
    assign off_calc  = addr_full[DEPTH_LOG2-1:0] - BASE_ADDR[DEPTH_LOG2-1:0];
    assign last_addr = (state_q == ADDR) && B_UTIL && (cnt == CNT_ADDR_LAST);
    assign commit    = (state_q == WDATA) && B_UTIL && (cnt == CNT_DATA_LAST);
    assign hit_now   = last_addr ? hit_calc : hit_q;

    counter #(.WIDTH(CNT_W)) u_cnt (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .rst   (cnt_clr),
        .incr  (cnt_incr),
        .cnt_o (cnt)
    );

    // State register
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (B_UTIL) state_d = ADDR;
            ADDR:  begin
                if (!B_UTIL)                     state_d = IDLE;
                else if (cnt == CNT_ADDR_LAST)   state_d = ACKA;
            end
            ACKA:  begin
                if (cnt == CNT_ACK_LAST) begin
                    if (!hit_q)    state_d = IDLE;
                    else if (rw_q) state_d = WDATA;
                    else           state_d = RDATA;
                end
            end
            WDATA: begin
                if (!B_UTIL)                     state_d = IDLE;
                else if (cnt == CNT_DATA_LAST)   state_d = ACKW;
            end
            ACKW:  if (cnt == CNT_ACK_LAST) state_d = IDLE;
            RDATA: if (B_UTIL && (cnt == CNT_DATA_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; outputs follow the state being entered.
    always_comb begin
        cnt_clr   = (state_d != state_q);
        cnt_incr  = 1'b0;
        ack_d     = 1'b0;
        wen_d     = commit;
        waddr_d   = S_WADDR;
        wdata_d   = S_WDATA;
        rd_d      = rd_q;
        bus_out_d = 1'b0;

        unique case (state_q)
            ADDR, WDATA, RDATA: cnt_incr = B_UTIL;
            ACKA, ACKW:         cnt_incr = 1'b1;
            default:            cnt_incr = 1'b0;
        endcase

        if (commit) begin
            waddr_d = off_q;
            wdata_d = wbyte;
        end

        if ((state_q == ACKA) && (state_d == RDATA)) begin
            rd_d = mem_q[off_q];
        end else if ((state_q == RDATA) && B_UTIL) begin
            rd_d = rd_q << 1;
        end

        ack_d     = ((state_d == ACKA) && hit_now) || (state_d == ACKW);
        bus_out_d = (state_d == RDATA) ? rd_d[DATA_BITS-1] : 1'b0;
    end

    // Registered outputs, shift registers and register file
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            B_ACK     <= 1'b0;
            B_BUS_OUT <= 1'b0;
            S_WEN     <= 1'b0;
            S_WADDR   <= '0;
            S_WDATA   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            hit_q     <= 1'b0;
            off_q     <= '0;
            rd_q      <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            B_ACK     <= ack_d;
            B_BUS_OUT <= bus_out_d;
            S_WEN     <= wen_d;
            S_WADDR   <= waddr_d;
            S_WDATA   <= wdata_d;
            rd_q      <= rd_d;
            if ((state_q == IDLE) && B_UTIL) rw_q <= B_RW;
            if (((state_q == IDLE) || (state_q == ADDR)) && B_UTIL)
                addr_q <= {B_BUS_IN, addr_q[ADDR_BITS-2:1]};
            if (last_addr) begin
                hit_q <= hit_calc;
                off_q <= off_calc;
            end
            if ((state_q == WDATA) && B_UTIL) wd_q <= {B_BUS_IN, wd_q[DATA_BITS-2:1]};
            if (commit) mem_q[off_q] <= wbyte;
        end
    end

endmodule
